// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Used by btn_debounce and sync_2ff.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reusable for any asynchronous input; synchronous active-low reset.
module sync_2ff
  import btn_debounce_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronised input, debounce FSM, registered level and press/release strobes.
// Optional long-hold strobe is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
  end

  logic             btn_sync;
  btn_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             level_d, press_d, release_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (btn_sync)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // The counter holds the number of consecutive qualifying samples seen in a *_WAIT state.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    next_state = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (btn_sync) next_state = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = HELD;
          cnt_next   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        cnt_next = '0;
        if (!btn_sync) next_state = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          next_state = HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = (state == PRESS_WAIT)   && (next_state == HELD);
    release_d = (state == RELEASE_WAIT) && (next_state == IDLE);
    level_d   = (next_state == HELD) || (next_state == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt;
  logic              long_run;
  logic              long_d;

  // Saturation at LONG_MAX is what makes the strobe fire only once per press.
  always_comb begin
    long_run = (state == HELD) || (state == RELEASE_WAIT);
    long_d   = long_run && (next_state != IDLE) && (long_cnt == LONG_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= long_d;
      if (press_d) begin
        long_cnt <= '0;
      end else if (long_run && long_cnt != LONG_MAX) begin
        long_cnt <= long_cnt + 1'b1;
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=10).
// Expected strobes are queued with their cycle number as stimulus is driven; a negedge monitor pops them.
module tb_btn_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int LAT  = DEB + 2;

`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe seen must match the head of the expectation queue in kind and cycle.
  always @(negedge clk) begin
    logic [2:0] strobes;
    ev_t        e;
    ev_kind_t   got;
    if (rst === 1'b1) begin
      strobes = {long_pulse, release_pulse, press_pulse};
      for (int k = 0; k < 3; k++) begin
        if (strobes[k] === 1'b1) begin
          got = ev_kind_t'(k);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe cycle %0d: got %s, expected none", cyc, got.name());
          end else begin
            e = exp_q.pop_front();
            if (e.kind !== got || e.at !== cyc) begin
              errors++;
              $display("FAIL strobe_order got %s at cycle %0d, expected %s at cycle %0d",
                       got.name(), cyc, e.kind.name(), e.at);
            end
          end
        end
      end
    end
  end

  task automatic step(input logic b);
    btn = b;
    @(posedge clk);
    #1;
  endtask

  // Drives seq then 'steady' copies of its last value; the final run decides the expected strobe.
  task automatic drive_seq(input string name, input logic seq[$], input int steady,
                           input bit with_long, input bit check_all);
    logic     fin;
    logic     expv;
    int       last;
    int       exp_at;
    int       n;
    ev_kind_t kind;
    fin  = seq[seq.size()-1];
    last = 0;
    for (int i = 1; i < seq.size(); i++)
      if (seq[i] != seq[i-1]) last = i;
    exp_at = cyc + 1 + last + LAT;
    kind   = fin ? EV_PRESS : EV_RELEASE;
    exp_q.push_back('{kind: kind, at: exp_at});
    if (with_long) exp_q.push_back('{kind: EV_LONG, at: exp_at + LONG});
    n = seq.size() + steady;
    for (int i = 0; i < n; i++) begin
      step((i < seq.size()) ? seq[i] : fin);
      if (cyc >= exp_at || check_all || cyc == exp_at - 1) begin
        expv = (cyc >= exp_at) ? fin : !fin;
        checks++;
        if (btn_level !== expv) begin
          errors++;
          $display("FAIL %s_level cycle %0d: got %b expected %b", name, cyc, btn_level, expv);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(logic'(i % 2));
      checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0000", cyc,
                 {btn_level, press_pulse, release_pulse, long_pulse});
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0);
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000",
               {btn_level, press_pulse, release_pulse, long_pulse});
    end
  endtask

  task automatic test_clean_press();
    drive_seq("clean_press", '{1'b1}, 19, LONG_EN, 1'b1);
  endtask

  task automatic test_release_bounce();
    drive_seq("release_bounce", '{1'b0, 1'b1, 1'b0}, 12, 1'b0, 1'b1);
  endtask

  task automatic test_press_bounce();
    drive_seq("press_bounce", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}, 20, LONG_EN, 1'b1);
    drive_seq("clean_release", '{1'b0}, 10, 1'b0, 1'b1);
  endtask

`ifdef BTN_LONG_PRESS_EN
  task automatic test_long_press();
    drive_seq("long_hold", '{1'b1}, 29, 1'b1, 1'b1);
    drive_seq("long_release", '{1'b0}, 10, 1'b0, 1'b1);
    drive_seq("short_hold", '{1'b1}, 4, 1'b0, 1'b0);
    drive_seq("short_release", '{1'b0}, 14, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_reset_mid_hold();
    drive_seq("pre_reset_press", '{1'b1}, 10, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
        errors++;
        $display("FAIL mid_hold_reset cycle %0d: got %b expected 0000", cyc,
                 {btn_level, press_pulse, release_pulse, long_pulse});
      end
    end
    rst = 1'b1;
    drive_seq("post_reset_press", '{1'b1}, 6, 1'b0, 1'b1);
    drive_seq("post_reset_release", '{1'b0}, 10, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_press_bounce();
`ifdef BTN_LONG_PRESS_EN
    test_long_press();
`endif
    test_reset_mid_hold();
    for (int i = 0; i < 20; i++) step(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: got %0d still pending, expected 0 (next %s at cycle %0d)",
               exp_q.size(), exp_q[0].kind.name(), exp_q[0].at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
